mem_port_arbiter: RTL

- Shares the single memory load/store port between two requesters: instruction fetch (IF) and execute-stage load/store (LS).
- Sits between the fetch/execute units and the external memory interface, which uses an 8-bit address, 16-bit data and a req/ready handshake.
- Serialises one transaction at a time. LS has fixed priority over IF.
- A watchdog aborts transactions that memory never acknowledges.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between IF and LS with a response watchdog
// Optional: define MEM_ARB_STARVE_GUARD_EN to bound consecutive LS grants while IF is waiting.
module mem_port_arbiter #(
   parameter int TIMEOUT      = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [7:0]  if_addr,
   output logic [15:0] if_data,
   output logic        if_valid,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [7:0]  ls_addr,
   input  logic [15:0] ls_wdata,
   output logic [15:0] ls_rdata,
   output logic        ls_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [7:0]  mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ready,
   output logic        err,
   output logic        owner,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t     state, state_n;
   logic [7:0] wd;
   logic       abort;
   logic       grant_ls, grant_if, done_ok, done_to;
   logic       force_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] starve;

   // Once LS has won STARVE_LIMIT times in a row against a waiting IF, IF takes the next slot.
   assign force_if = (starve == 4'(STARVE_LIMIT)) && if_req;

   always_ff @(posedge clk) begin
      if (rst)
         starve <= '0;
      else if (grant_if || (grant_ls && !if_req))
         starve <= '0;
      else if (grant_ls && starve != 4'hF)
         starve <= starve + 4'd1;
   end
`else
   assign force_if = 1'b0;
`endif

   always_comb begin
      state_n  = state;
      grant_ls = 1'b0;
      grant_if = 1'b0;
      done_ok  = 1'b0;
      done_to  = 1'b0;
      case (state)
         IDLE: begin
            if (ls_req && !force_if) begin
               grant_ls = 1'b1;
               state_n  = ACCESS;
            end else if (if_req) begin
               grant_if = 1'b1;
               state_n  = ACCESS;
            end
         end
         ACCESS: begin
            // A ready arriving on the expiry edge still counts as success.
            if (mem_ready) begin
               done_ok = 1'b1;
               state_n = RESPOND;
            end else if (wd == 8'(TIMEOUT - 1)) begin
               done_to = 1'b1;
               state_n = RESPOND;
            end
         end
         RESPOND: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_data   <= '0;
         ls_rdata  <= '0;
         if_valid  <= 1'b0;
         ls_valid  <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         owner     <= 1'b0;
         abort     <= 1'b0;
         wd        <= '0;
      end else begin
         if_valid <= 1'b0;
         ls_valid <= 1'b0;
         err      <= 1'b0;
         if (grant_ls) begin
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            owner     <= 1'b1;
            mem_we    <= ls_we;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
         end else if (grant_if) begin
            mem_req  <= 1'b1;
            busy     <= 1'b1;
            owner    <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
         end
         if (state == ACCESS && wd != 8'hFF)
            wd <= wd + 8'd1;
         if (done_ok) begin
            mem_req <= 1'b0;
            abort   <= 1'b0;
            if (!owner)
               if_data <= mem_rdata;
            else if (!mem_we)
               ls_rdata <= mem_rdata;
         end
         if (done_to) begin
            mem_req <= 1'b0;
            abort   <= 1'b1;
         end
         if (state == RESPOND) begin
            if_valid <= !owner;
            ls_valid <= owner;
            err      <= abort;
            busy     <= 1'b0;
            wd       <= '0;
         end
      end
   end

endmodule
